// File: rtl/gcn.sv
// GCN inference: fetches weights and features, computes FW = F*W^T, aggregates FW over an
// undirected COO edge list, then reports the per-node argmax class.
module gcn #(
  parameter int FEATURE_COLS      = 96,
  parameter int WEIGHT_ROWS       = 96,
  parameter int FEATURE_ROWS      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int FEATURE_WIDTH     = 5,
  parameter int WEIGHT_WIDTH      = 5,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH     = 13,
  parameter int NUM_OF_NODES      = 6,
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int COO_NUM_OF_ROWS   = 2,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int MAX_ADDRESS_WIDTH = 2
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0]          data_in,
  input  logic [0:COO_NUM_OF_ROWS-1][COO_BW-1:0]            coo_in,
  output logic [COO_BW-1:0]                                 coo_address,
  output logic [ADDRESS_WIDTH-1:0]                          read_address,
  output logic                                              enable_read,
  output logic                                              done,
  output logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]    max_addi_answer
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_READ_W   = 3'd1;
  localparam logic [2:0] S_READ_F   = 3'd2;
  localparam logic [2:0] S_READ_COO = 3'd3;
  localparam logic [2:0] S_ARGMAX   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [2:0] LAST_W = 3'(WEIGHT_COLS - 1);
  localparam logic [2:0] LAST_F = 3'(FEATURE_ROWS - 1);
  localparam logic [2:0] LAST_E = 3'(COO_NUM_OF_COLS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] FEAT_BASE = ADDRESS_WIDTH'(512);

  logic [2:0]                                           r_state;
  logic [2:0]                                           r_cnt;
  logic [ADDRESS_WIDTH-1:0]                             r_read_address;
  logic                                                 r_enable_read;
  logic [COO_BW-1:0]                                    r_coo_address;
  logic                                                 r_done;
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]       r_answer;
  logic [WEIGHT_WIDTH-1:0]                              r_w   [WEIGHT_COLS][WEIGHT_ROWS];
  logic [DOT_PROD_WIDTH-1:0]                            r_fw  [FEATURE_ROWS][WEIGHT_COLS];
  logic [DOT_PROD_WIDTH-1:0]                            r_agg [FEATURE_ROWS][WEIGHT_COLS];

  logic [DOT_PROD_WIDTH-1:0]                            w_dot [WEIGHT_COLS];
  logic [DOT_PROD_WIDTH-1:0]                            w_best [FEATURE_ROWS];
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]       w_arg;
  logic [COO_BW-1:0]                                    w_a;
  logic [COO_BW-1:0]                                    w_b;
  logic [COO_BW-1:0]                                    w_a_idx;
  logic [COO_BW-1:0]                                    w_b_idx;
  logic                                                 w_edge_ok;

  assign coo_address     = r_coo_address;
  assign read_address    = r_read_address;
  assign enable_read     = r_enable_read;
  assign done            = r_done;
  assign max_addi_answer = r_answer;

  // data_in holds the current feature row while in READ_F; all three columns in parallel.
  always_comb begin
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      w_dot[c] = '0;
      for (int k = 0; k < FEATURE_COLS; k++) begin
        w_dot[c] = w_dot[c] + DOT_PROD_WIDTH'(FEATURE_WIDTH'(data_in[k])) *
                              DOT_PROD_WIDTH'(r_w[c][k]);
      end
    end
  end

  always_comb begin
    w_a       = coo_in[0];
    w_b       = coo_in[1];
    w_a_idx   = w_a - COO_BW'(1);
    w_b_idx   = w_b - COO_BW'(1);
    w_edge_ok = (w_a != '0) && (int'(w_a) <= NUM_OF_NODES) &&
                (w_b != '0) && (int'(w_b) <= NUM_OF_NODES);
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_arg = '0;
    for (int n = 0; n < FEATURE_ROWS; n++) begin
      w_best[n] = r_agg[n][0];
      for (int c = 1; c < WEIGHT_COLS; c++) begin
        if (r_agg[n][c] > w_best[n]) begin
          w_best[n] = r_agg[n][c];
          w_arg[n]  = MAX_ADDRESS_WIDTH'(c);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_read_address <= '0;
      r_enable_read  <= 1'b0;
      r_coo_address  <= '0;
      r_done         <= 1'b0;
      r_answer       <= '0;
      for (int c = 0; c < WEIGHT_COLS; c++) begin
        for (int k = 0; k < WEIGHT_ROWS; k++) r_w[c][k] <= '0;
      end
      for (int n = 0; n < FEATURE_ROWS; n++) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          r_fw[n][c]  <= '0;
          r_agg[n][c] <= '0;
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_READ_W;
            r_enable_read  <= 1'b1;
            r_read_address <= '0;
            r_cnt          <= '0;
            for (int n = 0; n < FEATURE_ROWS; n++) begin
              for (int c = 0; c < WEIGHT_COLS; c++) r_agg[n][c] <= '0;
            end
          end
        end
        S_READ_W: begin
          for (int k = 0; k < WEIGHT_ROWS; k++) r_w[r_cnt][k] <= data_in[k];
          if (r_cnt == LAST_W) begin
            r_state        <= S_READ_F;
            r_cnt          <= '0;
            r_read_address <= FEAT_BASE;
          end else begin
            r_cnt          <= r_cnt + 3'd1;
            r_read_address <= ADDRESS_WIDTH'(r_cnt + 3'd1);
          end
        end
        S_READ_F: begin
          for (int c = 0; c < WEIGHT_COLS; c++) r_fw[r_cnt][c] <= w_dot[c];
          if (r_cnt == LAST_F) begin
            r_state        <= S_READ_COO;
            r_cnt          <= '0;
            r_enable_read  <= 1'b0;
            r_read_address <= '0;
            r_coo_address  <= '0;
          end else begin
            r_cnt          <= r_cnt + 3'd1;
            r_read_address <= FEAT_BASE + ADDRESS_WIDTH'(r_cnt + 3'd1);
          end
        end
        S_READ_COO: begin
          if (w_edge_ok) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
              if (w_a == w_b) begin
                r_agg[w_a_idx][c] <= r_agg[w_a_idx][c] + r_fw[w_a_idx][c];
              end else begin
                r_agg[w_a_idx][c] <= r_agg[w_a_idx][c] + r_fw[w_b_idx][c];
                r_agg[w_b_idx][c] <= r_agg[w_b_idx][c] + r_fw[w_a_idx][c];
              end
            end
          end
          if (r_cnt == LAST_E) begin
            r_state       <= S_ARGMAX;
            r_cnt         <= '0;
            r_coo_address <= '0;
          end else begin
            r_cnt         <= r_cnt + 3'd1;
            r_coo_address <= COO_BW'(r_cnt + 3'd1);
          end
        end
        S_ARGMAX: begin
          r_answer <= w_arg;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn.sv
// Directed and random vector bench for gcn: memory/COO model, address-sequence checks and
// per-node argmax comparison against hand-computed or modelled answers.
module tb_gcn;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [0:95][4:0]     data_in;
  logic [0:1][2:0]      coo_in;
  logic [2:0]           coo_address;
  logic [12:0]          read_address;
  logic                 enable_read;
  logic                 done;
  logic [0:5][1:0]      max_addi_answer;

  always #5 clk = ~clk;

  gcn dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .data_in        (data_in),
    .coo_in         (coo_in),
    .coo_address    (coo_address),
    .read_address   (read_address),
    .enable_read    (enable_read),
    .done           (done),
    .max_addi_answer(max_addi_answer)
  );

  typedef struct packed {
    logic [2:0]             wmode;
    logic [2:0]             fmode;
    logic [0:5][0:1][2:0]   edges;
    logic                   use_model;
    logic [0:5][1:0]        ans;
  } vec_t;

  localparam logic [0:5][0:1][2:0] RING = {3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4,
                                           3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd1};
  localparam logic [0:5][0:1][2:0] STAR = {3'd1, 3'd2, 3'd1, 3'd3, 3'd1, 3'd4,
                                           3'd1, 3'd5, 3'd1, 3'd6, 3'd2, 3'd3};
  localparam logic [0:5][0:1][2:0] ODD  = {3'd1, 3'd1, 3'd2, 3'd0, 3'd7, 3'd3,
                                           3'd4, 3'd4, 3'd2, 3'd3, 3'd5, 3'd6};

  logic [4:0] mw [3][96];
  logic [4:0] mf [6][96];
  logic [2:0] medge [6][2];
  vec_t       vecs [7];
  int         checks = 0;
  int         errors = 0;
  int         aq[$];
  int         cq[$];

  // Memory drives data one negedge after the address register changes.
  always @(negedge clk) begin : mem_model
    int ra;
    ra = int'(read_address);
    for (int k = 0; k < 96; k++) begin
      if (ra < 3) data_in[k] = mw[ra][k];
      else if (ra >= 512 && ra < 518) data_in[k] = mf[ra-512][k];
      else data_in[k] = 5'd0;
    end
    for (int j = 0; j < 2; j++) begin
      coo_in[j] = (int'(coo_address) < 6) ? medge[coo_address][j] : 3'd0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic sample();
    if (enable_read) aq.push_back(int'(read_address));
    if (cq.size() == 0 || cq[$] != int'(coo_address)) cq.push_back(int'(coo_address));
  endtask

  task automatic load(input vec_t v);
    logic [4:0] t [6][3] = '{'{5'd3, 5'd1, 5'd2}, '{5'd0, 5'd4, 5'd1}, '{5'd2, 5'd2, 5'd5},
                             '{5'd1, 5'd0, 5'd0}, '{5'd0, 5'd0, 5'd7}, '{5'd6, 5'd6, 5'd1}};
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 96; k++) begin
        case (v.wmode)
          3'd0:    mw[c][k] = 5'(c + 1);
          3'd1:    mw[c][k] = 5'd5;
          3'd2:    mw[c][k] = (c == 1) ? 5'd1 : 5'd0;
          3'd3:    mw[c][k] = (k == c) ? 5'd1 : 5'd0;
          3'd4:    mw[c][k] = (c == 0) ? 5'd31 : ((c == 1) ? 5'd30 : 5'd20);
          default: mw[c][k] = 5'($urandom_range(0, 31));
        endcase
      end
    end
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 96; k++) begin
        case (v.fmode)
          3'd0:    mf[r][k] = 5'd1;
          3'd1:    mf[r][k] = 5'((r * 7 + k) % 32);
          3'd2:    mf[r][k] = (r == 1) ? 5'd1 : 5'd0;
          3'd3:    mf[r][k] = (k < 3) ? t[r][k] : 5'd0;
          3'd4:    mf[r][k] = 5'd31;
          default: mf[r][k] = 5'($urandom_range(0, 31));
        endcase
      end
    end
    for (int e = 0; e < 6; e++) begin
      for (int j = 0; j < 2; j++) begin
        medge[e][j] = v.use_model ? 3'($urandom_range(1, 6)) : v.edges[e][j];
      end
    end
  endtask

  function automatic logic [0:5][1:0] golden();
    logic [15:0]     fw  [6][3];
    logic [15:0]     agg [6][3];
    logic [0:5][1:0] res;
    int              a, b, best;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 3; c++) begin
        fw[r][c]  = 16'd0;
        agg[r][c] = 16'd0;
        for (int k = 0; k < 96; k++) begin
          fw[r][c] = fw[r][c] + 16'(int'(mf[r][k]) * int'(mw[c][k]));
        end
      end
    end
    for (int e = 0; e < 6; e++) begin
      a = int'(medge[e][0]);
      b = int'(medge[e][1]);
      if (a >= 1 && a <= 6 && b >= 1 && b <= 6) begin
        for (int c = 0; c < 3; c++) begin
          if (a == b) agg[a-1][c] = agg[a-1][c] + fw[a-1][c];
          else begin
            agg[a-1][c] = agg[a-1][c] + fw[b-1][c];
            agg[b-1][c] = agg[b-1][c] + fw[a-1][c];
          end
        end
      end
    end
    for (int n = 0; n < 6; n++) begin
      best = 0;
      for (int c = 1; c < 3; c++) if (agg[n][c] > agg[n][best]) best = c;
      res[n] = 2'(best);
    end
    return res;
  endfunction

  task automatic run_case(input int idx, input bit do_reset);
    vec_t            v;
    logic [0:5][1:0] want;
    int              lat;
    int              addr_exp [9] = '{0, 1, 2, 512, 513, 514, 515, 516, 517};
    v = vecs[idx];
    load(v);
    want = v.use_model ? golden() : v.ans;
    if (do_reset) begin
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check($sformatf("reset_outs_%0d", idx),
            {done, enable_read, read_address, coo_address, max_addi_answer}, 64'd0);
      reset = 1'b0;
    end
    aq.delete();
    cq.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    sample();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      sample();
    end
    check($sformatf("done_latency_%0d(lat=%0d)", idx, lat), {63'd0, (done && lat <= 24)}, 64'd1);
    check($sformatf("addr_count_%0d", idx), aq.size(), 9);
    for (int i = 0; i < 9 && i < aq.size(); i++) begin
      check($sformatf("addr_%0d_%0d", idx, i), aq[i], addr_exp[i]);
    end
    check($sformatf("coo_steps_%0d", idx), cq.size(), 7);
    for (int i = 0; i < 6 && i < cq.size(); i++) begin
      check($sformatf("coo_%0d_%0d", idx, i), cq[i], i);
    end
    check($sformatf("answers_%0d", idx), max_addi_answer, want);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("done_hold_%0d", idx), {done, enable_read, max_addi_answer},
          {1'b1, 1'b0, want});
    start = 1'b0;
  endtask

  task automatic abort_test();
    load(vecs[0]);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    start = 1'b0;
    check("abort_in_read_f", {enable_read, 3'(read_address - 13'd512)}, {1'b1, 3'd2});
    reset = 1'b1;
    #1;
    check("abort_reset_outs", {done, enable_read, read_address, coo_address, max_addi_answer},
          64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_reset_hold", {done, enable_read, read_address, coo_address, max_addi_answer},
          64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_case(0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    vecs[0] = '{wmode: 3'd0, fmode: 3'd0, edges: RING, use_model: 1'b0,
                ans: {2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2}};
    vecs[1] = '{wmode: 3'd1, fmode: 3'd1, edges: RING, use_model: 1'b0,
                ans: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[2] = '{wmode: 3'd2, fmode: 3'd2, edges: STAR, use_model: 1'b0,
                ans: {2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0}};
    vecs[3] = '{wmode: 3'd3, fmode: 3'd3, edges: ODD, use_model: 1'b0,
                ans: {2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd2}};
    // Column sums wrap: col0 92256 -> 26720, col2 59520; doubled, col2 still wins after wrap.
    vecs[4] = '{wmode: 3'd4, fmode: 3'd4, edges: RING, use_model: 1'b0,
                ans: {2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2}};
    vecs[5] = '{wmode: 3'd5, fmode: 3'd5, edges: RING, use_model: 1'b1, ans: '0};
    vecs[6] = '{wmode: 3'd5, fmode: 3'd5, edges: RING, use_model: 1'b1, ans: '0};
    repeat (2) @(posedge clk);
    for (int i = 0; i < 7; i++) run_case(i, 1'b1);
    abort_test();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcn.md
# gcn

Graph Convolutional Network inference block. It fetches a 3-column weight matrix and a 6×96 feature matrix from external memory, computes the 6×3 product FW, and aggregates FW over the graph adjacency given as a 6-edge COO list. It then outputs, per node, the column index of the maximum aggregated score. It is the top-level compute block, driven by an external memory model and a COO table.

## Interface
Parameters:
- FEATURE_COLS, 96, features per node (equals WEIGHT_ROWS)
- WEIGHT_ROWS, 96, length of each weight column
- FEATURE_ROWS, 6, number of nodes
- WEIGHT_COLS, 3, number of classes
- FEATURE_WIDTH / WEIGHT_WIDTH, 5, unsigned element width
- DOT_PROD_WIDTH, 16, product/accumulator width
- ADDRESS_WIDTH, 13, memory address width
- NUM_OF_NODES, 6, graph nodes
- COO_NUM_OF_COLS, 6, number of edges
- COO_NUM_OF_ROWS, 2, COO rows (endpoint A, endpoint B)
- COO_BW, $clog2(COO_NUM_OF_COLS), COO element and coo_address width
- MAX_ADDRESS_WIDTH, 2, argmax index width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- start  in  1  level; begin computation when high in IDLE
- data_in  in  [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0]  one weight column or one feature row; element 0 is index 0
- coo_in  in  [0:1][COO_BW-1:0]  edge endpoints at coo_address
- coo_address  out  COO_BW  edge index 0..5
- read_address  out  ADDRESS_WIDTH  0..2 = weight column c; 512+r = feature row r
- enable_read  out  1  memory read request
- done  out  1  results valid
- max_addi_answer  out  [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]  per-node argmax

## Operation
- States: IDLE → READ_W → READ_F → READ_COO → ARGMAX → DONE.
- IDLE: outputs at reset values. Go to READ_W on start=1.
- READ_W: enable_read=1, read_address = 0, 1, 2 on consecutive cycles. Capture each column into a weight register file (3×96×5 bits).
- READ_F: read_address = 512+r for r = 0..5. On capture of row r, compute all three dot products in parallel: FW[r][c] = Σk F[r][k]·W[c][k]. Sums are unsigned, truncated modulo 2^16.
- READ_COO: coo_address = 0..5. Each edge (a = coo_in[0], b = coo_in[1]) holds 1-based node ids 1..6.
- Aggregation is undirected with no self-loops. For each of the 3 columns: AGG[a-1] += FW[b-1] and AGG[b-1] += FW[a-1], modulo 2^16. Accumulators cleared at start.
- Edge with a == b: adds FW[a-1] to AGG[a-1] once.
- Endpoint value 0 or >6: the edge is ignored.
- ARGMAX: max_addi_answer[n] = index of the largest AGG[n][c]. Ties resolve to the lowest index.
- DONE: done=1; outputs held stable until reset. start is ignored in DONE.

## Timing
- Reset values: done=0, enable_read=0, read_address=0, coo_address=0, max_addi_answer all 0. All internal state cleared.
- Read latency is one cycle. Address and enable_read are driven from registers after posedge t. Memory updates data_in/coo_in at the following negedge. The DUT samples at posedge t+1. Reads are pipelined, one per cycle.
- enable_read is 0 outside READ_W/READ_F. coo_address is always valid (COO is read unconditionally).
- Latency from the first cycle start is sampled high to done=1: ≤ 24 cycles. Nominal breakdown: 3+1 weight, 6+1 feature, 6+1 COO, 1 argmax, 1 done register.
- Reset asserted mid-operation aborts immediately, returns to IDLE, and clears the accumulators. A new start then restarts from READ_W.
- start dropping after IDLE exit has no effect.

## Test plan
- Address sequence: after reset release with start=1, enable_read asserted with read_address exactly 0, 1, 2, 512..517 in order; coo_address steps 0..5; done rises within 24 cycles.
- All features 1; weights col0=1, col1=2, col2=3; ring edges (1,2)(2,3)(3,4)(4,5)(5,6)(6,1) → FW row = [96,192,288]; every node has AGG [192,384,576] → all answers 2.
- All weights equal (5), arbitrary features, ring graph → three-way tie everywhere → all answers 0.
- Star edges (1,2)(1,3)(1,4)(1,5)(1,6)(2,3); feature row r=1 elsewhere 0; weights col1=1, others 0 → node 1 answer 1; nodes with zero scores answer 0.
- Reset pulsed during READ_F, then start → done high, correct results matching a fresh run; done=0 and outputs=0 during reset.
- Random 5-bit data versus a golden model including 16-bit wrap → all six answers match.
